// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide unit with a private HI/LO register pair.
//
// A start request is accepted only while the unit is idle. The result of
// mult/multu/div/divu is computed when the request is accepted and held in
// pending registers. Busy then stays high for MULT_CYCLES or DIV_CYCLES
// cycles. HI/LO are updated on the edge where Busy falls. mthi/mtlo write
// HI or LO directly from A in one edge, and Busy stays low for them.
//
// Handshake: Start is a one-cycle request qualified by MDUOp. It is accepted
// only on an edge where Busy=0. A request made while Busy=1 is dropped
// without any effect, and the requester is expected to hold off.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   Start   in   qualifies MDUOp for one cycle
//   MDUOp   in   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   A, B    in   operands (rs, rt)
//   ReadHI  in   1 selects HI onto MDURD, 0 selects LO
//   Busy    out  computation in progress
//   HI, LO  out  architectural HI/LO registers
//   MDURD   out  ReadHI ? HI : LO (combinational)

module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        ReadHI,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDURD
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi_q;
    logic [31:0] pend_lo_q;
    logic        pend_wr_q;

    // Arithmetic datapath, evaluated against the live operands. It is
    // only sampled on the accepting edge.
    logic [63:0] mul_s;
    logic [63:0] mul_u;
    logic        div_signed;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] div_q;
    logic [31:0] div_r;

    always_comb begin
        mul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        mul_u = {32'd0, A} * {32'd0, B};
    end

    // A single unsigned divider serves both div and divu. Signed divide
    // works on magnitudes and restores the signs afterwards. The quotient
    // is negative when the operand signs differ. The remainder takes the
    // sign of the dividend. For 0x80000000 / -1, the magnitude quotient is
    // 0x80000000 and the signs match, so the wrapped result falls out
    // with no special case.
    always_comb begin
        div_signed = (MDUOp == OP_DIV);
        dvd_mag    = (div_signed && A[31]) ? (32'd0 - A) : A;
        dvs_mag    = (div_signed && B[31]) ? (32'd0 - B) : B;
        uq         = 32'd0;
        ur         = 32'd0;
        if (dvs_mag != 32'd0) begin
            uq = dvd_mag / dvs_mag;
            ur = dvd_mag % dvs_mag;
        end
        div_q = (div_signed && (A[31] ^ B[31])) ? (32'd0 - uq) : uq;
        div_r = (div_signed && A[31]) ? (32'd0 - ur) : ur;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        case (MDUOp)
                            OP_MULT, OP_MULTU: begin
                                pend_hi_q <= (MDUOp == OP_MULT) ? mul_s[63:32] : mul_u[63:32];
                                pend_lo_q <= (MDUOp == OP_MULT) ? mul_s[31:0]  : mul_u[31:0];
                                pend_wr_q <= 1'b1;
                                cnt_q     <= 32'(MULT_CYCLES);
                                state_q   <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi_q <= div_r;
                                pend_lo_q <= div_q;
                                // Divide by zero runs the full time but leaves HI/LO alone.
                                pend_wr_q <= (B != 32'd0);
                                cnt_q     <= 32'(DIV_CYCLES);
                                state_q   <= RUN;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // The counter is loaded with N. The commit happens when it
                    // reads 1, so Busy stays high for exactly N cycles.
                    if (cnt_q == 32'd1) begin
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        cnt_q   <= 32'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy  = (state_q == RUN);
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDURD = ReadHI ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Testbench for mdu_unit. It applies directed operations with hand-computed
// results. A cycle-level arithmetic model is checked against the outputs
// on every falling clock edge.

module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        ReadHI;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDURD;

  always #5 clk = ~clk;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .MDUOp  (MDUOp),
    .A      (A),
    .B      (B),
    .ReadHI (ReadHI),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO),
    .MDURD  (MDURD)
  );

  int vectors     = 0;
  int miscompares = 0;
  int busy_run    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the architectural HI/LO, the cycles left before the pending
  // result lands, and the result itself. The arithmetic uses 64-bit
  // integers.
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  bit          m_pok = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge reset) begin
    longint          sp;
    longint          sr;
    longint unsigned up;
    if (!reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_pok = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pok) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (Start) begin
      case (MDUOp)
        3'd1: begin
          sp = longint'($signed(A)) * longint'($signed(B));
          m_phi = sp[63:32]; m_plo = sp[31:0]; m_pok = 1'b1; m_left = MC;
        end
        3'd2: begin
          up = longint'({32'd0, A}) * longint'({32'd0, B});
          m_phi = up[63:32]; m_plo = up[31:0]; m_pok = 1'b1; m_left = MC;
        end
        3'd3: begin
          m_pok = (B != 0); m_left = DC;
          if (B != 0) begin
            sp = longint'($signed(A)) / longint'($signed(B));
            sr = longint'($signed(A)) % longint'($signed(B));
            m_plo = sp[31:0]; m_phi = sr[31:0];
          end
        end
        3'd4: begin
          m_pok = (B != 0); m_left = DC;
          if (B != 0) begin
            m_plo = A / B; m_phi = A % B;
          end
        end
        3'd5: m_hi = A;
        3'd6: m_lo = A;
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset) begin
      check("busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
      check("mdurd", MDURD, ReadHI ? m_hi : m_lo);
    end
  end

  // Counts the cycles Busy is high. It samples just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (Busy) busy_run++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    Start = 1'b1; MDUOp = op; A = a; B = b;
    ReadHI = 1'($urandom_range(0, 1));
    @(posedge clk); #2;
    // Scramble the operands after capture. The result must not depend on them.
    Start = 1'b0; MDUOp = 3'd0; A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!Busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: Busy still high after 60 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    busy_run = 0;
    drive_op(op, a, b);
    wait_idle(name);
    check({name, "_busy_cycles"}, 32'(busy_run), 32'(exp_busy));
    check({name, "_hi"}, HI, exp_hi);
    check({name, "_lo"}, LO, exp_lo);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0; ReadHI = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    #1 reset = 1'b1;

    run_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, MC, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  3'd4, 32'd7,         32'd2, DC, 32'd1,         32'd3);

    // Preload HI/LO, then divide by zero. The preloaded values must survive.
    run_op("mthi",  3'd5, 32'h1234, 32'd0, 0, 32'h1234, 32'd3);
    run_op("mtlo",  3'd6, 32'h5678, 32'd0, 0, 32'h1234, 32'h5678);
    run_op("div0",  3'd3, 32'd99,   32'd0, DC, 32'h1234, 32'h5678);
    ReadHI = 1'b1; #1;
    check("div0_mdurd_hi", MDURD, 32'h1234);
    ReadHI = 1'b0; #1;
    check("div0_mdurd_lo", MDURD, 32'h5678);

    // Signed overflow quotient.
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);
    run_op("divu_big", 3'd4, 32'hFFFF_FFFF, 32'd16, DC, 32'd15, 32'h0FFF_FFFF);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk); #3 reset = 1'b0; #1;
    check("areset_busy", {31'd0, Busy}, 32'd0);
    check("areset_hi", HI, 32'd0);
    check("areset_lo", LO, 32'd0);
    @(posedge clk); #2 reset = 1'b1;

    // Requests made while Busy are dropped.
    busy_run = 0;
    drive_op(3'd1, 32'd3, 32'd4);
    Start = 1'b1; MDUOp = 3'd6; A = 32'hDEAD; B = 32'd0;
    @(posedge clk); #2;
    Start = 1'b1; MDUOp = 3'd3; A = 32'd9; B = 32'd2;
    @(posedge clk); #2;
    Start = 1'b0; MDUOp = 3'd0;
    wait_idle("collide");
    check("collide_busy_cycles", 32'(busy_run), 32'(MC));
    check("collide_hi", HI, 32'd0);
    check("collide_lo", LO, 32'd12);

    // Reset in the middle of a divide.
    busy_run = 0;
    drive_op(3'd4, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0; #1;
    check("midop_busy", {31'd0, Busy}, 32'd0);
    check("midop_hi", HI, 32'd0);
    check("midop_lo", LO, 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    run_op("post_reset_multu", 3'd2, 32'd2, 32'd2, MC, 32'd0, 32'd4);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit with its own HI/LO register pair.
- Sits in the execute stage. Operands come straight from the general register file read ports (RD1 -> A, RD2 -> B). MDURD is selected by the write-back mux so mfhi/mflo results can be written back to the register file.
- Multi-cycle: asserts Busy while computing; the control unit stalls any later mult/div/mfhi/mflo/mthi/mtlo while Busy=1.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >= 1).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  qualifies MDUOp for one cycle.
- MDUOp  input  3  0=NOP, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO, 7=reserved (treated as NOP).
- A  input  32  operand 1 (rs).
- B  input  32  operand 2 (rt).
- ReadHI  input  1  1 selects HI onto MDURD, 0 selects LO.
- Busy  output  1  computation in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MDURD  output  32  combinational: ReadHI ? HI : LO.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, internal counter=0, pending result discarded. Applies immediately, including mid-operation. No operation can start until reset=1.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, counter active.
- IDLE, Start=1, op 1-4, on edge T:
  - A and B latched.
  - Result computed into internal pending registers; HI/LO are not touched.
  - Counter loaded with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - Busy=1 from edge T through edge T+N, where N is the cycle count, i.e. exactly N cycles high.
- RUN: counter decrements each edge. On the edge where it expires:
  - HI/LO take the pending result.
  - Busy falls on that same edge; return to IDLE.
  - New HI/LO are visible in the first cycle with Busy=0.
- IDLE, Start=1, op 5 (MTHI): HI<=A on the edge; LO unchanged; Busy stays 0.
- IDLE, Start=1, op 6 (MTLO): LO<=A on the edge; HI unchanged; Busy stays 0.
- Start=1 while Busy=1: ignored entirely for every op, including MTHI/MTLO. No latching, no restart, no HI/LO write.
- Start=1 on the edge where Busy falls: Busy=1 at that edge, so Start is ignored.
- Start=0 or NOP/reserved op: no state change.
- Arithmetic:
  - MULT: {HI,LO} = signed(A) * signed(B), 64-bit.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0, DIV or DIVU): runs the full DIV_CYCLES with Busy asserted, then HI and LO remain at their previous values.
- HI/LO hold their values throughout RUN. MDURD during RUN returns the old HI/LO; the stall logic is responsible for preventing that read.
- Operands are captured at Start. A/B changing during RUN has no effect.

Test Plan:
- Reset: reset=0 asserted asynchronously mid-cycle -> HI=LO=0, Busy=0 immediately, before the next clk edge.
- MULT signed: A=0xFFFFFFFE (-2), B=3, Start pulse -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV signed: A=-7 (0xFFFFFFF9), B=2 -> Busy high exactly 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU with A=7, B=2 -> LO=3, HI=1.
- Divide by zero: preload with MTHI A=0x1234, MTLO A=0x5678, then DIV with B=0 -> Busy 10 cycles; HI=0x1234, LO=0x5678 unchanged; MDURD follows ReadHI.
- Busy-collision: start MULT 3*4; during cycle 2 pulse Start with MTLO A=0xDEAD, and at cycle 3 pulse DIV -> both ignored; final HI=0, LO=12; Busy total 5 cycles.
- Reset mid-op: start DIVU 100/7, drop reset at cycle 4 -> Busy=0, HI=LO=0 immediately. After reset release, a MULTU 2*2 -> LO=4, HI=0 after 5 cycles.
